pattern_framer: RTL and testbench

PATTERN_FRAMER -- requirements
Module: pattern_framer

---
 rtl/pattern_framer.sv | 168 ++++++++++++++++
 tb/tb_pattern_framer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_framer.sv
// Sync-pattern framer: hunts for a PAT_LEN-word sync pattern, then writes
// BURST_LEN payload words with a 1-cycle registered strobe.
//
// state      | meaning
// ST_IDLE    | hunting for the first pattern word
// ST_SYNC    | partial pattern matched, idx_q = next word expected
// ST_PAYLOAD | writing payload words, pcnt_q = words written so far
module pattern_framer #(
  parameter int                     DW        = 16,
  parameter int                     PAT_LEN   = 2,
  parameter logic [PAT_LEN*DW-1:0]  PAT       = {16'h00AA, 16'h0055},
  parameter int                     BURST_LEN = 4,
  parameter int                     MAX_GAP   = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          EN,
  input  logic [DW-1:0] DIN,
  input  logic          DVALID,
  output logic          WREN,
  output logic [DW-1:0] WDATA,
  output logic          FRAME_START,
  output logic          FRAME_DONE,
  output logic          ERR_TIMEOUT,
  output logic          BUSY,
  output logic [15:0]   FRAME_CNT
);

  typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_PAYLOAD} state_t;

  localparam logic [3:0]  IDX_LAST = 4'(PAT_LEN - 1);
  localparam logic [15:0] PCNT_LAST = 16'(BURST_LEN - 1);
  localparam logic [7:0]  GAP_LAST = 8'(MAX_GAP - 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic [7:0]  gcnt_q, gcnt_d;

  logic [DW-1:0] pat_w [PAT_LEN];
  logic [DW-1:0] pat_cur;
  logic          match0, match_cur, last_pat, gap_hit;
  logic          wren_d, start_d, done_d, tmo_d;

  // First expected word sits in the most-significant slice of PAT
  for (genvar i = 0; i < PAT_LEN; i++) begin : g_pat
    assign pat_w[i] = PAT[(PAT_LEN-1-i)*DW +: DW];
  end

  always_comb begin
    pat_cur = pat_w[0];
    for (int i = 0; i < PAT_LEN; i++)
      if (idx_q == 4'(i)) pat_cur = pat_w[i];
  end

  assign match0    = DVALID && (DIN == pat_w[0]);
  assign match_cur = DVALID && (DIN == pat_cur);
  assign last_pat  = (idx_q == IDX_LAST);
  assign gap_hit   = !DVALID && (gcnt_q == GAP_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      pcnt_q  <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pcnt_q  <= pcnt_d;
      gcnt_q  <= gcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pcnt_d  = pcnt_q;
    gcnt_d  = DVALID ? 8'd0 : gcnt_q + 8'd1;
    if (!EN) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      pcnt_d  = '0;
      gcnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          idx_d  = '0;
          pcnt_d = '0;
          gcnt_d = '0;
          if (match0) begin
            if (PAT_LEN == 1) state_d = ST_PAYLOAD;
            else begin
              state_d = ST_SYNC;
              idx_d   = 4'd1;
            end
          end
        end
        ST_SYNC: begin
          if (DVALID) begin
            if (match_cur) begin
              if (last_pat) begin
                state_d = ST_PAYLOAD;
                idx_d   = '0;
                pcnt_d  = '0;
              end else idx_d = idx_q + 4'd1;
            end else if (match0) idx_d = 4'd1;
            else begin
              state_d = ST_IDLE;
              idx_d   = '0;
            end
          end else if (gap_hit) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            gcnt_d  = '0;
          end
        end
        ST_PAYLOAD: begin
          if (DVALID) begin
            if (pcnt_q == PCNT_LAST) begin
              state_d = ST_IDLE;
              pcnt_d  = '0;
            end else pcnt_d = pcnt_q + 16'd1;
          end else if (gap_hit) begin
            state_d = ST_IDLE;
            pcnt_d  = '0;
            gcnt_d  = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          pcnt_d  = '0;
          gcnt_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    wren_d  = EN && (state_q == ST_PAYLOAD) && DVALID;
    done_d  = wren_d && (pcnt_q == PCNT_LAST);
    start_d = EN && (((state_q == ST_IDLE) && match0 && (PAT_LEN == 1)) ||
                     ((state_q == ST_SYNC) && match_cur && last_pat));
    tmo_d   = EN && (state_q != ST_IDLE) && gap_hit;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      WREN        <= 1'b0;
      WDATA       <= '0;
      FRAME_START <= 1'b0;
      FRAME_DONE  <= 1'b0;
      ERR_TIMEOUT <= 1'b0;
      FRAME_CNT   <= '0;
    end else begin
      WREN        <= wren_d;
      FRAME_START <= start_d;
      FRAME_DONE  <= done_d;
      ERR_TIMEOUT <= tmo_d;
      if (wren_d) WDATA <= DIN;
      if (done_d) FRAME_CNT <= FRAME_CNT + 16'd1;
    end
  end

  assign BUSY = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pattern_framer.sv
// Bench for pattern_framer: directed frame scenarios plus random traffic,
// checked cycle by cycle against a frame-level reference model.
module tb_pattern_framer;

  logic        CLK = 1'b0;
  logic        RST_N, EN, DVALID;
  logic [15:0] DIN;
  logic        WREN, FRAME_START, FRAME_DONE, ERR_TIMEOUT, BUSY;
  logic [15:0] WDATA, FRAME_CNT;

  logic        en2, dv2;
  logic [7:0]  din2, wdata2;
  logic        wren2, start2, done2, tmo2, busy2;
  logic [15:0] cnt2;

  int n_checks = 0;
  int n_errors = 0;
  int n_wr = 0, n_start = 0, n_tmo = 0;

  // reference model state: words of sync matched, payload words written
  bit          m_pay;
  int          m_sync, m_words, m_gap;
  logic        e_wren, e_start, e_done, e_tmo, e_busy;
  logic [15:0] e_wdata, e_cnt;

  pattern_framer dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .DIN(DIN), .DVALID(DVALID),
    .WREN(WREN), .WDATA(WDATA), .FRAME_START(FRAME_START),
    .FRAME_DONE(FRAME_DONE), .ERR_TIMEOUT(ERR_TIMEOUT), .BUSY(BUSY),
    .FRAME_CNT(FRAME_CNT)
  );

  pattern_framer #(
    .DW(8), .PAT_LEN(3), .PAT({8'hA5, 8'h5A, 8'hC3}), .BURST_LEN(1), .MAX_GAP(4)
  ) dut2 (
    .CLK(CLK), .RST_N(RST_N), .EN(en2), .DIN(din2), .DVALID(dv2),
    .WREN(wren2), .WDATA(wdata2), .FRAME_START(start2),
    .FRAME_DONE(done2), .ERR_TIMEOUT(tmo2), .BUSY(busy2),
    .FRAME_CNT(cnt2)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] pat_word(int i);
    return (i == 0) ? 16'h00AA : 16'h0055;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pay = 0; m_sync = 0; m_words = 0; m_gap = 0;
    e_wren = 0; e_start = 0; e_done = 0; e_tmo = 0; e_busy = 0;
    e_wdata = '0; e_cnt = '0;
  endtask

  // One clock of the frame rules: sync hunt, payload burst, gap abort.
  task automatic model_step(logic [15:0] d, logic v, logic e);
    e_wren = 0; e_start = 0; e_done = 0; e_tmo = 0;
    if (!e) begin
      m_pay = 0; m_sync = 0; m_gap = 0;
    end else if (m_pay) begin
      if (v) begin
        m_gap = 0; m_words++;
        e_wren = 1; e_wdata = d;
        if (m_words == 4) begin
          e_done = 1; e_cnt = e_cnt + 16'd1; m_pay = 0;
        end
      end else begin
        m_gap++;
        if (m_gap == 4) begin e_tmo = 1; m_pay = 0; m_gap = 0; end
      end
    end else if (m_sync > 0) begin
      if (v) begin
        m_gap = 0;
        if (d == pat_word(m_sync)) begin
          m_sync++;
          if (m_sync == 2) begin
            m_sync = 0; m_pay = 1; m_words = 0; e_start = 1;
          end
        end else m_sync = (d == pat_word(0)) ? 1 : 0;
      end else begin
        m_gap++;
        if (m_gap == 4) begin e_tmo = 1; m_sync = 0; m_gap = 0; end
      end
    end else if (v && d == pat_word(0)) begin
      m_gap = 0; m_sync = 1;
    end
    e_busy = m_pay || (m_sync > 0);
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step(DIN, DVALID, EN);
    #1;
    if (WREN === 1'b1) n_wr++;
    if (FRAME_START === 1'b1) n_start++;
    if (ERR_TIMEOUT === 1'b1) n_tmo++;
    chk("wren", WREN, e_wren);
    chk("wdata", WDATA, e_wdata);
    chk("frame_start", FRAME_START, e_start);
    chk("frame_done", FRAME_DONE, e_done);
    chk("err_timeout", ERR_TIMEOUT, e_tmo);
    chk("busy", BUSY, e_busy);
    chk("frame_cnt", FRAME_CNT, e_cnt);
  endtask

  task automatic drive(logic [15:0] d, logic v);
    DIN = d; DVALID = v;
    tick();
  endtask

  task automatic drive_seq(input logic [15:0] words [], input int idle_after);
    foreach (words[i]) drive(words[i], 1'b1);
    for (int i = 0; i < idle_after; i++) drive(16'h0, 1'b0);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_wren"}, WREN, 0);
    chk({tag, "_wdata"}, WDATA, 0);
    chk({tag, "_start"}, FRAME_START, 0);
    chk({tag, "_done"}, FRAME_DONE, 0);
    chk({tag, "_tmo"}, ERR_TIMEOUT, 0);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_cnt"}, FRAME_CNT, 0);
  endtask

  initial begin
    logic [7:0] p2 [4];
    int start0, wr0, thresh;
    p2 = '{8'hA5, 8'h5A, 8'hC3, 8'h7E};

    RST_N = 0; EN = 1; DIN = 0; DVALID = 0;
    en2 = 1; din2 = 0; dv2 = 0;
    model_reset();
    #12;
    chk_all_zero("reset");
    chk("reset_wren2", wren2, 0);
    chk("reset_cnt2", cnt2, 0);
    RST_N = 1;

    // second configuration: 3-word sync, single-word burst
    for (int i = 0; i < 4; i++) begin
      din2 = p2[i]; dv2 = 1;
      tick();
      if (i == 2) chk("p2_start", start2, 1);
      if (i < 3)  chk("p2_no_wren", wren2, 0);
    end
    dv2 = 0;
    chk("p2_wren", wren2, 1);
    chk("p2_wdata", wdata2, 8'h7E);
    chk("p2_done", done2, 1);
    chk("p2_cnt", cnt2, 1);
    chk("p2_busy", busy2, 0);
    tick();
    chk("p2_wren_off", wren2, 0);
    chk("p2_wdata_hold", wdata2, 8'h7E);

    // basic frame
    n_wr = 0; n_start = 0;
    drive_seq('{16'h00AA, 16'h0055, 16'h0011, 16'h0022, 16'h0033, 16'h0044}, 2);
    chk("basic_wr_count", n_wr, 4);
    chk("basic_start_count", n_start, 1);
    chk("basic_cnt", FRAME_CNT, 1);

    // re-sync on repeated first word, then a broken pattern
    drive_seq('{16'h00AA, 16'h00AA, 16'h0055, 16'h0001, 16'h0002, 16'h0003, 16'h0004}, 1);
    chk("resync_cnt", FRAME_CNT, 2);
    start0 = n_start;
    drive_seq('{16'h00AA, 16'h0012, 16'h0055}, 2);
    chk("broken_no_start", n_start, start0);

    // gap of 4 aborts, gap of 3 is tolerated
    n_tmo = 0;
    drive_seq('{16'h00AA, 16'h0055, 16'h0001}, 4);
    chk("gap4_tmo", n_tmo, 1);
    chk("gap4_busy", BUSY, 0);
    chk("gap4_cnt", FRAME_CNT, 2);
    drive_seq('{16'h00AA, 16'h0055, 16'h0001}, 3);
    drive_seq('{16'h0002, 16'h0003, 16'h0004}, 1);
    chk("gap3_tmo", n_tmo, 1);
    chk("gap3_cnt", FRAME_CNT, 3);

    // back-to-back frames, pattern word carried as payload
    wr0 = n_wr;
    drive_seq('{16'h00AA, 16'h0055, 16'h0001, 16'h00AA, 16'h0003, 16'h0004,
                16'h00AA, 16'h0055, 16'h0005, 16'h0006, 16'h0007, 16'h0008}, 1);
    chk("b2b_cnt", FRAME_CNT, 5);
    chk("b2b_wr", n_wr - wr0, 8);

    // enable drop while in sync
    drive(16'h00AA, 1);
    EN = 0;
    drive(16'h0055, 1);
    chk("en_busy", BUSY, 0);
    chk("en_start", FRAME_START, 0);
    EN = 1;
    drive_seq('{16'h0011, 16'h0022}, 1);
    chk("en_cnt_held", FRAME_CNT, 5);

    // asynchronous reset mid-payload
    drive_seq('{16'h00AA, 16'h0055, 16'h0011, 16'h0022}, 0);
    #2 RST_N = 0;
    #1 chk_all_zero("midreset");
    model_reset();
    DVALID = 0;
    @(posedge CLK); #1;
    chk("midreset_hold_wren", WREN, 0);
    chk("midreset_hold_tmo", ERR_TIMEOUT, 0);
    RST_N = 1;
    drive_seq('{16'h00AA, 16'h0055, 16'h0001, 16'h0002, 16'h0003, 16'h0004}, 1);
    chk("post_reset_cnt", FRAME_CNT, 1);

    // random traffic against the model
    thresh = 8;
    for (int i = 0; i < 3000; i++) begin
      int r;
      if (i % 100 == 0) thresh = $urandom_range(3, 10);
      EN = ($urandom_range(0, 59) != 0);
      r = $urandom_range(0, 5);
      DIN = (r < 2) ? 16'h00AA : (r < 4) ? 16'h0055 : 16'($urandom);
      DVALID = ($urandom_range(0, 9) < thresh);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
